// File: rtl/keypad_digit_encoder.sv
// rtl/keypad_digit_encoder.sv - debounced one-hot keypad encoder with BCD entry buffer and tick divider
module keypad_digit_encoder #(
   parameter int NUM_KEYS        = 10,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int NUM_DIGITS      = 4,
   parameter int DIV             = 100
) (
   input  logic                               Clk,
   input  logic                               Reset,
   input  logic                               Enablen,
   input  logic [NUM_KEYS-1:0]                Keypad,
   input  logic                               Clear,
   output logic [3:0]                         D,
   output logic                               loadn,
   output logic [4*NUM_DIGITS-1:0]            Digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]    DigitCount,
   output logic                               Error,
   output logic                               pgt_1Hz
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DC_W  = $clog2(NUM_DIGITS + 1);
   localparam int DIV_W = $clog2(DIV);

   // Counter value at which the current sample completes the debounce window
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic [NUM_KEYS-1:0]       pat;
   logic                      multi_seen;
   logic [DIV_W-1:0]          div_cnt;

   logic                      key_single;
   logic                      key_multi;
   logic                      key_zero;
   logic [3:0]                key_code;
   logic                      load_fire;
   logic                      err_fire;
   logic [4*NUM_DIGITS-1:0]   digits_base;
   logic [4*NUM_DIGITS-1:0]   digits_next;
   logic [DC_W-1:0]           count_base;
   logic [DC_W-1:0]           count_next;

   // Bit index of the highest set key line; only meaningful when one line is set
   function automatic logic [3:0] encode(input logic [NUM_KEYS-1:0] k);
      encode = 4'd0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (k[i]) encode = 4'(i);
      end
   endfunction

   // Classify the current sample and decide whether this edge loads a key or flags a multi-press
   always_comb begin
      key_single = ($countones(Keypad) == 1);
      key_multi  = ($countones(Keypad) > 1);
      key_zero   = (Keypad == '0);
      key_code   = encode(Keypad);
      // A single debounce sample means the entering edge itself accepts the key
      load_fire  = !Enablen &&
                   (((state == IDLE) && key_single && (DEBOUNCE_CYCLES == 1)) ||
                    ((state == PRESS_DB) && (Keypad == pat) && (cnt == DB_LAST)));
      // One Error pulse per multi-press; re-armed once the pattern stops being multi-hot
      err_fire   = (state == IDLE) && !Enablen && key_multi && !multi_seen;
      // Clear takes effect before a coincident shift so the new digit survives it
      digits_base = Clear ? '0 : Digits;
      digits_next = digits_base << 4;
      digits_next[3:0] = key_code;
      count_base  = Clear ? '0 : DigitCount;
      count_next  = (count_base == DC_MAX) ? count_base : count_base + DC_W'(1);
   end

   // Debounce FSM with registered strobe, code and entry buffer
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         pat        <= '0;
         multi_seen <= 1'b0;
         D          <= 4'd0;
         loadn      <= 1'b1;
         Error      <= 1'b0;
         Digits     <= '0;
         DigitCount <= '0;
      end else begin
         loadn      <= 1'b1;
         Error      <= 1'b0;
         multi_seen <= key_multi && (multi_seen || err_fire);
         if (Clear) begin
            Digits     <= '0;
            DigitCount <= '0;
         end
         if (load_fire) begin
            D          <= key_code;
            loadn      <= 1'b0;
            Digits     <= digits_next;
            DigitCount <= count_next;
         end
         if (err_fire) Error <= 1'b1;

         case (state)
            IDLE: begin
               if (!Enablen && key_single) begin
                  pat <= Keypad;
                  cnt <= CNT_W'(1);
                  state <= (DEBOUNCE_CYCLES == 1) ? HELD : PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (Enablen || (Keypad != pat)) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HELD: begin
               // Any nonzero pattern keeps us here: no auto-repeat, no key change
               if (key_zero) begin
                  cnt   <= CNT_W'(1);
                  state <= (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE_DB;
               end
            end
            RELEASE_DB: begin
               if (!key_zero) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Free-running time-base divider, one-cycle tick after the terminal count
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_cnt <= '0;
         pgt_1Hz <= 1'b0;
      end else if (div_cnt == DIV_MAX) begin
         div_cnt <= '0;
         pgt_1Hz <= 1'b1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
         pgt_1Hz <= 1'b0;
      end
   end

endmodule
